// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O pause responder.
// FSM state encoding and the control unit's iotype encoding.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RELEASE    = 3'd1,
    WAIT_PRESS = 3'd2,
    HOLD       = 3'd3,
    ACK        = 3'd4
  } io_state_t;

  localparam logic IOTYPE_IN  = 1'b0;
  localparam logic IOTYPE_OUT = 1'b1;

endpackage

// File: rtl/io_debounce.sv
// Confirm-button synchroniser plus saturating debounce counter.
// Ports: clk, rst_n, btn_raw in; btn_s (synchronised), press out.
module io_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_s,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DB_CYCLES);

  logic          meta;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      meta  <= btn_raw;
      btn_s <= meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!btn_s) begin
      cnt <= '0;
    end else if (cnt != DB_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign press = (cnt == DB_MAX);

endmodule

// File: rtl/io_responder.sv
// Peripheral side of the CPU I/O pause four-phase handshake.
// In: clk, rst_n, iopause, iotype, out_value, sw_raw, btn_raw.
// Out: switches, iostate, led_out, wait_user.
import io_pkg::*;

module io_responder #(
  parameter int DB_CYCLES    = 50000,
  parameter int OUT_AUTO_ACK = 1,
  parameter int OUT_HOLD     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iopause,
  input  logic        iotype,
  input  logic [15:0] out_value,
  input  logic [15:0] sw_raw,
  input  logic        btn_raw,
  output logic [15:0] switches,
  output logic        iostate,
  output logic [15:0] led_out,
  output logic        wait_user
);

  localparam int HW = (OUT_HOLD > 1) ? $clog2(OUT_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(OUT_HOLD - 1);
  localparam logic AUTO = (OUT_AUTO_ACK != 0);

  io_state_t     state, next;
  logic          type_q, type_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          led_ld, sw_ld;
  logic          btn_s, press;

  io_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btn_s  (btn_s),
    .press  (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      type_q    <= IOTYPE_IN;
      hold_cnt  <= '0;
      switches  <= '0;
      led_out   <= '0;
      iostate   <= 1'b0;
      wait_user <= 1'b0;
    end else begin
      state    <= next;
      type_q   <= type_d;
      hold_cnt <= hold_d;
      if (sw_ld)  switches <= sw_raw;
      if (led_ld) led_out  <= out_value;
      // Decoded from next-state so iostate never
      // combinationally follows iopause.
      iostate   <= (next == ACK);
      wait_user <= (next == RELEASE) ||
                   (next == WAIT_PRESS);
    end
  end

  always_comb begin
    next   = state;
    type_d = type_q;
    hold_d = '0;
    led_ld = 1'b0;
    sw_ld  = 1'b0;
    unique case (state)
      IDLE: begin
        if (iopause) begin
          type_d = iotype;
          if (iotype == IOTYPE_OUT) begin
            led_ld = 1'b1;
            next   = AUTO ? HOLD : RELEASE;
          end else begin
            next = RELEASE;
          end
        end
      end
      RELEASE: begin
        // A button still held from an earlier request
        // must be let go before a new press counts.
        if (!iopause)    next = IDLE;
        else if (!btn_s) next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (!iopause) begin
          next = IDLE;
        end else if (press) begin
          next  = ACK;
          sw_ld = (type_q == IOTYPE_IN);
        end
      end
      HOLD: begin
        if (!iopause)                  next = IDLE;
        else if (hold_cnt == HOLD_LAST) next = ACK;
        else hold_d = hold_cnt + 1'b1;
      end
      ACK: begin
        if (!iopause) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule
